// File: rtl/bit_serial_adder.sv
// Bit-serial adder that processes one bit per clock, LSB first, through an IDLE/SHIFT/DONE FSM.
// Defining OVERFLOW_FLAG_EN adds a registered two's-complement overflow output, ovf.
module bit_serial_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] psum;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s_bit;
  logic             c_next;
  logic             last_bit;

  always_comb begin
    s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    c_next   = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Result registers load only on the final bit, so sum/cout never expose partial values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            psum  <= '0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          psum  <= {s_bit, psum[WIDTH-1:1]};
          carry <= c_next;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            sum  <= {s_bit, psum[WIDTH-1:1]};
            cout <= c_next;
`ifdef OVERFLOW_FLAG_EN
            ovf  <= carry ^ c_next;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and exhaustive self-checking bench for bit_serial_adder at WIDTH=4.
// Also builds with OVERFLOW_FLAG_EN defined, which adds the ovf checks.
module tb_bit_serial_adder;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef OVERFLOW_FLAG_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef OVERFLOW_FLAG_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one add, waits for done within a bounded window, checks latency/result, returns in IDLE.
  task automatic run_add(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input logic [W-1:0] es, input logic ec, input logic eo);
    int lat;
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    for (int i = 1; i <= int'(W) + 4 && lat == 0; i++) begin
      step();
      if (done) lat = i;
    end
    check({tag, "_latency"}, lat, W);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
`ifdef OVERFLOW_FLAG_EN
    check({tag, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("unexpected x on expected ovf");
`endif
    step();
    check({tag, "_done_once"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] xa, xb, xs;
    logic         xc;
    logic [W:0]   r;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum",  sum, 0);
    check("rst_cout", cout, 0);
    rst = 1'b0;

    // Start right after reset release; 0011+0101 = 1000, signed overflow.
    run_add("basic", 4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0, 1'b1);
    run_add("wrap",  4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);

    // Operand hold and start ignore: 0110+0111+1 = 1110.
    a = 4'b0110; b = 4'b0111; cin = 1'b1; start = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) begin
      a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom);
      step();
      if (i < 4) check("hold_no_early_done", done, 0);
    end
    check("hold_done", done, 1);
    check("hold_sum", sum, 4'b1110);
    check("hold_cout", cout, 0);
    a = 4'b0010; b = 4'b0001; cin = 1'b0;
    step();
    check("hold_idle_gap", busy, 0);
    check("hold_sum_held", sum, 4'b1110);
    step();
    check("hold_restart_at_6", busy, 1);
    start = 1'b0;
    repeat (3) step();
    check("second_not_done", done, 0);
    step();
    check("second_done", done, 1);
    check("second_sum", sum, 4'b0011);
    check("second_cout", cout, 0);
    step();
    check("second_idle", busy, 0);

    // Mid-operation reset two cycles after acceptance.
    a = 4'b1001; b = 4'b0100; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_sum",  sum, 0);
    check("midrst_cout", cout, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("midrst_no_done", done, 0);
    end
    rst = 1'b0;
    run_add("after_rst", 4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0);

    for (int i = 0; i < 512; i++) begin
      xa = W'(i);
      xb = W'(i >> 4);
      xc = i[8];
      r  = {1'b0, xa} + {1'b0, xb} + {{W{1'b0}}, xc};
      xs = r[W-1:0];
      run_add("exh", xa, xb, xc, xs, r[W],
              (xa[W-1] == xb[W-1]) && (xs[W-1] != xa[W-1]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder.md
BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 Parameter WIDTH, default 4, sets the operand and sum width in bits; legal range 2..16.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to add; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured at the accepting edge.
REQ-006 b  input  WIDTH  operand B; captured at the accepting edge.
REQ-007 cin  input  1  carry-in; captured at the accepting edge.
REQ-008 busy  output  1  high while state is not IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 sum  output  WIDTH  registered result of the last completed add.
REQ-011 cout  output  1  registered carry-out of the last completed add.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 IDLE -> SHIFT occurs on an edge where start=1; the same edge loads the a and b shift registers, loads the carry flop with cin, and clears the bit counter.
REQ-014 In SHIFT, each edge SHALL compute one bit, LSB first: s = a0^b0^c and c' = a0&b0 | c&(a0^b0). s shifts into the MSB of the partial-sum register; the a and b registers shift right; the counter increments.
REQ-015 SHIFT -> DONE occurs on the edge that processes bit WIDTH-1. That edge SHALL load sum from the completed partial-sum register and cout from the final carry.
REQ-016 In DONE, done=1 for exactly one cycle; the next edge SHALL return the FSM to IDLE unconditionally.
REQ-017 Latency: start accepted at edge k; sum and cout valid and done=1 after edge k+WIDTH; IDLE after edge k+WIDTH+1. Minimum start-to-start spacing is WIDTH+2 cycles.
REQ-018 start in SHIFT or DONE SHALL be ignored; it is not queued.
REQ-019 Changes on a, b or cin after the accepting edge SHALL NOT affect the result.
REQ-020 sum and cout SHALL hold their value until the next completion and SHALL NOT show partial results.
REQ-021 Arithmetic is unsigned and modulo 2^WIDTH. {cout,sum} SHALL equal a+b+cin exactly, including the all-ones wrap-around.

Reset
REQ-022 While rst=1: state=IDLE; busy=0; done=0; sum=0; cout=0; shift registers, counter and carry flop cleared.
REQ-023 Reset asserted during SHIFT or DONE SHALL abort the add with no done pulse, and SHALL leave sum and cout at 0.
REQ-024 On the first rising edge after rst falls, start=1 SHALL be accepted normally.

Configuration
REQ-025 Macro OVERFLOW_FLAG_EN controls a signed-overflow output.
REQ-026 With OVERFLOW_FLAG_EN defined: an extra output port ovf (1 bit) exists. It is loaded at the REQ-015 edge with the carry into bit WIDTH-1 XOR cout (two's-complement overflow), holds like sum, and resets to 0.
REQ-027 Without OVERFLOW_FLAG_EN: there is no ovf port and no related logic; all other behaviour is identical.

Verification (WIDTH=4)
REQ-028 Basic add: a=0011, b=0101, cin=0, start for one cycle -> done high exactly 4 cycles after the accepting edge; sum=1000, cout=0; ovf=1 when the macro is enabled.
REQ-029 Wrap-around: a=1111, b=1111, cin=1 -> sum=1111, cout=1; ovf=0.
REQ-030 Operand hold and start ignore: after acceptance, change a, b and cin every cycle and hold start=1 throughout -> result matches the captured operands; a second add starts only from IDLE, with start-to-start spacing of 6 cycles.
REQ-031 Mid-operation reset: assert rst 2 cycles after acceptance -> no done pulse; sum=0, cout=0, busy=0; a following add of 0001+0001 gives sum=0010.
REQ-032 Exhaustive run: all 512 combinations of a, b and cin, back-to-back -> every {cout,sum} equals a+b+cin, with exactly one done pulse per add.
